// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size/state encodings and the alignment check for dmem_banked_rw
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   // Offset arrives zero-extended to 3 bits so one check serves 32- and 64-bit words.
   function automatic logic is_aligned(input logic [2:0] offset, input logic [1:0] size,
                                       input int lanes);
      logic [2:0] mask;
      mask = 3'((4'd1 << size) - 4'd1);
      if (size == SZ_DWORD && lanes < 8) return 1'b0;
      return (offset & mask) == 3'd0;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/data placement and load extract/extend
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]                    size,
   input  logic [$clog2(DATA_W/8)-1:0]   offset,
   input  logic                          req_unsigned,
   input  logic [DATA_W-1:0]             wdata,
   input  logic [DATA_W-1:0]             rword,
   output logic [DATA_W/8-1:0]           wbe,
   output logic [DATA_W-1:0]             wword,
   output logic [DATA_W-1:0]             rdata
);
   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);

   logic [OFF_W+2:0]  bit_shift;
   logic [3:0]        nbytes;
   logic [6:0]        nbits;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] keep_mask;
   logic              sign_bit;

   always_comb begin
      bit_shift = {offset, 3'b000};
      nbytes    = 4'd1 << size;
      nbits     = {nbytes, 3'b000};
      wword     = wdata << bit_shift;
      wbe       = '0;
      for (int i = 0; i < LANES; i++)
         wbe[i] = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
      shifted = rword >> bit_shift;
      if (int'(nbits) >= DATA_W) keep_mask = '1;
      else                       keep_mask = ~({DATA_W{1'b1}} << nbits);
      // Top bit of a contiguous low mask marks the sign position; zero for full-width loads.
      sign_bit = |(shifted & (keep_mask ^ (keep_mask >> 1))) && (int'(nbits) < DATA_W);
      rdata    = (shifted & keep_mask) | ((sign_bit && !req_unsigned) ? ~keep_mask : '0);
   end

endmodule

// File: rtl/dmem_banked_rw.sv
// rtl/dmem_banked_rw.sv - byte-addressed data RAM with valid/ready request/response
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range word index raises resp_err instead of wrapping.
module dmem_banked_rw
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);
   localparam int LANES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(LANES);
   localparam int IDX_W  = ADDR_W - OFF_W;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [OFF_W-1:0]  offset;
   logic [IDX_W-1:0]  word_idx;
   logic [MEM_AW-1:0] mem_idx;
   logic              accept;
   logic              bad_addr;
   logic              do_write;
   logic [LANES-1:0]  wbe;
   logic [DATA_W-1:0] wword;
   logic [DATA_W-1:0] rdata_ext;

   assign offset   = req_addr[OFF_W-1:0];
   assign word_idx = req_addr[ADDR_W-1:OFF_W];
   assign mem_idx  = MEM_AW'(word_idx % IDX_W'(DEPTH));
   assign accept   = (state_q == ST_IDLE) && req_valid;
`ifdef DMEM_BOUNDS_CHECK_EN
   assign bad_addr = !is_aligned(3'(offset), req_size, LANES) || (word_idx >= IDX_W'(DEPTH));
`else
   assign bad_addr = !is_aligned(3'(offset), req_size, LANES);
`endif
   assign do_write = accept && req_write && !bad_addr;

   dmem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size         (req_size),
      .offset       (offset),
      .req_unsigned (req_unsigned),
      .wdata        (req_wdata),
      .rword        (mem_q[mem_idx]),
      .wbe          (wbe),
      .wword        (wword),
      .rdata        (rdata_ext)
   );

   // Contents are deliberately not reset; writes are suppressed while rst_n is low.
   always_ff @(posedge clk) begin
      if (rst_n && do_write) begin
         for (int i = 0; i < LANES; i++)
            if (wbe[i]) mem_q[mem_idx][8*i +: 8] <= wword[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid)  state_d = ST_RESP;
         ST_RESP: if (resp_ready) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_RESP);
   end

   always_comb begin
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      if (accept) begin
         resp_err_d   = bad_addr;
         resp_rdata_d = (bad_addr || req_write) ? '0 : rdata_ext;
      end
   end

   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_banked_rw.sv
// tb/tb_dmem_banked_rw.sv - directed plus randomized checks of dmem_banked_rw against a byte-array model
module tb_dmem_banked_rw;
   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   int total = 0;
   int bad   = 0;

   logic [7:0] ref_mem [4*DEPTH];

   dmem_banked_rw #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: little-endian byte array; results follow the size/alignment/extension rules directly.
   function automatic void model_op(input logic w, input logic [1:0] sz, input logic u,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] erd, output logic eerr);
      int unsigned n, word, base;
      logic [63:0] v;
      n    = 1 << sz;
      word = a / 4;
      eerr = (sz == 2'd3) || ((a % n) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
      if (word >= DEPTH) eerr = 1'b1;
`endif
      erd = '0;
      if (eerr) return;
      base = (word % DEPTH) * 4 + (a % 4);
      if (w) begin
         for (int i = 0; i < int'(n); i++) ref_mem[base + i] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < int'(n); i++) v = v | (64'(ref_mem[base + i]) << (8*i));
         if (!u && n < 4 && v[8*n-1]) v = v | (~64'h0 << (8*n));
         erd = v[31:0];
      end
   endfunction

   task automatic xfer(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
      @(negedge clk);
      chk("ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("resp_valid_after_accept", {31'd0, resp_valid}, 32'd1);
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk); #1;
   endtask

   task automatic op_check(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] rd, erd;
      logic        er, eerr;
      model_op(w, sz, u, a, wd, erd, eerr);
      xfer(w, sz, u, a, wd, rd, er);
      chk({tag, "_rdata"}, rd, erd);
      chk({tag, "_err"}, {31'd0, er}, {31'd0, eerr});
   endtask

   initial begin
      logic [31:0] held;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++)
         op_check("fill", 1'b1, 2'd2, 1'b0, 32'(4*i), $urandom);

      op_check("st_w20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hF0F0F0F0);
      op_check("ld_w20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      chk("ld_w20_const", resp_rdata, 32'hF0F0F0F0);
      op_check("st_b21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h85);
      op_check("ld_sb21", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
      chk("ld_sb21_const", resp_rdata, 32'hFFFFFF85);
      op_check("ld_ub21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
      chk("ld_ub21_const", resp_rdata, 32'h00000085);
      op_check("ld_w20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      chk("ld_w20b_const", resp_rdata, 32'hF0F085F0);
      op_check("ld_h23_mis", 1'b0, 2'd1, 1'b0, 32'h23, 32'h0);
      chk("ld_h23_err_const", {31'd0, resp_err}, 32'd1);
      op_check("st_w22_mis", 1'b1, 2'd2, 1'b0, 32'h22, 32'h11223344);
      op_check("ld_w20_unchanged", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      chk("ld_w20_unchanged_const", resp_rdata, 32'hF0F085F0);
      op_check("ld_dword_illegal", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0);

      // Response held by back-pressure; a competing request must be ignored.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h20; resp_ready = 1'b0;
      @(posedge clk); #1;
      held = resp_rdata;
      chk("hold_first_rdata", held, 32'hF0F085F0);
      req_write = 1'b1; req_wdata = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
         chk("hold_rdata", resp_rdata, 32'hF0F085F0);
      end
      @(negedge clk); req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_ready", {31'd0, req_ready}, 32'd1);
      op_check("ld_after_ignored_store", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

      // Reset pulse while a response is pending.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h20; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pre_rst_resp_valid", {31'd0, resp_valid}, 32'd1);
      @(negedge clk); rst_n = 1'b0; #1;
      chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1; resp_ready = 1'b1;
      op_check("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      chk("ld_after_rst_const", resp_rdata, 32'hF0F085F0);

      op_check("st_w0_base", 1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A55A5A);
      op_check("st_oob", 1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'hDEADBEEF);
      op_check("ld_w0_after_oob", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
`ifdef DMEM_BOUNDS_CHECK_EN
      chk("oob_word0_const", resp_rdata, 32'hA5A55A5A);
`else
      chk("oob_word0_const", resp_rdata, 32'hDEADBEEF);
`endif

      for (int k = 0; k < 80; k++)
         op_check("rand", 1'($urandom), 2'($urandom), 1'($urandom),
                  32'($urandom_range(0, 8*DEPTH-1)), $urandom);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
